// File: rtl/video_vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// video_vram_arbiter_if
//   One request/response channel of the VRAM arbiter. The same bundle is used
//   for both client masters (A and B) and for the shared VRAM bus itself.
//
//   Signals
//     request  requester -> responder  transaction pending, held until ready
//     rw       requester -> responder  direction, 1 = write
//     address  requester -> responder  byte address
//     wdata    requester -> responder  write data
//     rdata    responder -> requester  read data, valid with ready
//     ready    responder -> requester  one-cycle completion pulse
//
//   Modports
//     master : the side that issues transactions
//     slave  : the side that completes them
// ---------------------------------------------------------------------------
interface video_vram_arbiter_if;
  logic        request;
  logic        rw;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output request, rw, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  request, rw, address, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/video_vram_arbiter.sv
// ---------------------------------------------------------------------------
// video_vram_arbiter
//   Shares a single VRAM bus between a CPU write buffer (port A) and the video
//   line-buffer fill engine (port B). B has fixed priority so scanline fetches
//   make their hblank deadline; a burst limiter hands A one transaction once
//   B has won MAX_B_BURST grants in a row while A was waiting.
//
//   Parameters
//     MAX_B_BURST  consecutive B grants tolerated while A is pending (1..255)
//
//   Ports
//     i_clock   in   system clock, rising edge
//     i_reset   in   synchronous reset, active high
//     s_pa      slave  master A channel (request/rw/address/wdata -> rdata/ready)
//     s_pb      slave  master B channel, same shape as A
//     m_bus     master VRAM channel; ready is a one-cycle completion
//     o_grant   out  current owner: 01 = A, 10 = B, 00 = none
//
//   Timing
//     IDLE samples requests and registers the winner onto the bus (one cycle
//     request-to-bus latency). The owner's ready/rdata are passed straight
//     through from the bus in the completion cycle; the next edge drops the
//     bus request and returns to IDLE, so there is always at least one idle
//     bus cycle between transactions.
// ---------------------------------------------------------------------------
module video_vram_arbiter #(
  parameter int unsigned MAX_B_BURST = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  video_vram_arbiter_if.slave         s_pa,
  video_vram_arbiter_if.slave         s_pb,
  video_vram_arbiter_if.master        m_bus,
  output logic [1:0]                  o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_A = 2'd1,
    ST_BUSY_B = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_B_BURST);
  localparam logic [1:0] LP_GRANT_A   = 2'b01;
  localparam logic [1:0] LP_GRANT_B   = 2'b10;

  state_t      r_state;
  logic        r_bus_request;
  logic        r_bus_rw;
  logic [31:0] r_bus_address;
  logic [31:0] r_bus_wdata;
  logic [1:0]  r_grant;
  logic [7:0]  r_burst_cnt;

  logic w_burst_full;
  logic w_sel_b;
  logic w_sel_a;
  logic w_done_a;
  logic w_done_b;

  // B keeps priority unless A has already watched a full burst go by.
  assign w_burst_full = (r_burst_cnt == LP_MAX_BURST);
  assign w_sel_b      = s_pb.request && !(s_pa.request && w_burst_full);
  assign w_sel_a      = !w_sel_b && s_pa.request;

  // Completion is forwarded only to the current owner. The reset term keeps a
  // ready that lands in the reset cycle from leaking out as a completion.
  assign w_done_a = (r_state == ST_BUSY_A) && m_bus.ready && !i_reset;
  assign w_done_b = (r_state == ST_BUSY_B) && m_bus.ready && !i_reset;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_bus_request <= 1'b0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_grant       <= 2'b00;
      r_burst_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_b) begin
            r_bus_request <= 1'b1;
            r_bus_rw      <= s_pb.rw;
            r_bus_address <= s_pb.address;
            r_bus_wdata   <= s_pb.wdata;
            r_grant       <= LP_GRANT_B;
            r_state       <= ST_BUSY_B;
            // Only B grants that A actually had to wait through are counted.
            if (s_pa.request)
              r_burst_cnt <= w_burst_full ? r_burst_cnt : r_burst_cnt + 8'd1;
            else
              r_burst_cnt <= '0;
          end else if (w_sel_a) begin
            r_bus_request <= 1'b1;
            r_bus_rw      <= s_pa.rw;
            r_bus_address <= s_pa.address;
            r_bus_wdata   <= s_pa.wdata;
            r_grant       <= LP_GRANT_A;
            r_state       <= ST_BUSY_A;
            r_burst_cnt   <= '0;
          end else begin
            // Nothing granted here means A is not waiting.
            r_burst_cnt   <= '0;
          end
        end

        ST_BUSY_A, ST_BUSY_B: begin
          // Bus fields are held; requester inputs are not looked at again.
          if (m_bus.ready) begin
            r_bus_request <= 1'b0;
            r_grant       <= 2'b00;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_bus_request <= 1'b0;
          r_grant       <= 2'b00;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_bus.request = r_bus_request;
  assign m_bus.rw      = r_bus_rw;
  assign m_bus.address = r_bus_address;
  assign m_bus.wdata   = r_bus_wdata;
  assign o_grant       = r_grant;

  assign s_pa.ready = w_done_a;
  assign s_pa.rdata = w_done_a ? m_bus.rdata : '0;
  assign s_pb.ready = w_done_b;
  assign s_pb.rdata = w_done_b ? m_bus.rdata : '0;

endmodule

// File: tb/tb_video_vram_arbiter.sv
module tb_video_vram_arbiter;
  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;

  always #5 clk = ~clk;

  video_vram_arbiter_if pa ();
  video_vram_arbiter_if pb ();
  video_vram_arbiter_if bus ();

  video_vram_arbiter #(.MAX_B_BURST(MAXB)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .s_pa    (pa),
    .s_pb    (pb),
    .m_bus   (bus),
    .o_grant (grant)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xact_t;

  int          tests = 0;
  int          fails = 0;
  xact_t       qa[$];
  xact_t       qb[$];
  logic [1:0]  glog[$];
  logic [31:0] alog[$];
  bit          rsp_en = 1'b1;
  int          fixed_dly = -1;
  int          dly = -1;
  bit          force_rd = 1'b0;
  logic [31:0] force_val = '0;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- VRAM responder ----------------
  initial begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_en && bus.ready) begin
        bus.ready = 1'b0;
        bus.rdata = $urandom;
        dly       = -1;
      end else if (rsp_en && bus.request && !rst) begin
        if (dly < 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        if (dly == 0) begin
          bus.ready = 1'b1;
          bus.rdata = force_rd ? force_val : hsh(bus.address);
        end else begin
          dly--;
        end
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic a_xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    xact_t x;
    x.rw = rw; x.addr = addr; x.wdata = wd;
    x.rdata = force_rd ? force_val : hsh(addr);
    qa.push_back(x);
    pa.request = 1'b1; pa.rw = rw; pa.address = addr; pa.wdata = wd;
    for (int n = 0; n <= 400; n++) begin
      @(negedge clk);
      if (pa.ready) break;
      if (n == 400) begin
        tests++; fails++;
        $display("FAIL a_timeout: no ready for addr %h", addr);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      pa.request = 1'b0; pa.address = $urandom; pa.wdata = $urandom;
    end
  endtask

  task automatic b_xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    xact_t x;
    x.rw = rw; x.addr = addr; x.wdata = wd;
    x.rdata = force_rd ? force_val : hsh(addr);
    qb.push_back(x);
    pb.request = 1'b1; pb.rw = rw; pb.address = addr; pb.wdata = wd;
    for (int n = 0; n <= 400; n++) begin
      @(negedge clk);
      if (pb.ready) break;
      if (n == 400) begin
        tests++; fails++;
        $display("FAIL b_timeout: no ready for addr %h", addr);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      pb.request = 1'b0; pb.address = $urandom; pb.wdata = $urandom;
    end
  endtask

  // ---------------- monitor / reference model ----------------
  // Arbitration reference: whenever the bus was free, the requests seen on the
  // previous cycle decide the owner. streak = B wins A has sat through.
  logic       prev_rst = 1'b1, prev_pa = 1'b0, prev_pb = 1'b0, prev_done = 1'b0;
  logic [1:0] prev_g = 2'b00;
  logic [1:0] eg;
  int         streak = 0;

  always @(negedge clk) begin
    if (rst) begin
      streak = 0; prev_rst = 1'b1; prev_g = 2'b00; prev_done = 1'b0;
      prev_pa = 1'b0; prev_pb = 1'b0;
    end else begin
      if (!prev_rst && prev_g == 2'b00) begin
        if (prev_pb && !(prev_pa && streak == MAXB)) eg = 2'b10;
        else if (prev_pa)                            eg = 2'b01;
        else                                         eg = 2'b00;
        chk("grant_decision", 32'(grant), 32'(eg));
        if (eg == 2'b10 && prev_pa) streak = (streak < MAXB) ? streak + 1 : MAXB;
        else                        streak = 0;
        if (grant != 2'b00) begin
          glog.push_back(grant);
          alog.push_back(bus.address);
        end
      end
      if (prev_done) begin
        chk("release_grant", 32'(grant), 32'd0);
        chk("release_busreq", 32'(bus.request), 32'd0);
      end
      chk("pa_ready", 32'(pa.ready), 32'(bus.ready && grant == 2'b01));
      chk("pb_ready", 32'(pb.ready), 32'(bus.ready && grant == 2'b10));
      if (grant == 2'b01 || grant == 2'b10) begin
        if ((grant == 2'b01 ? qa.size() : qb.size()) == 0) begin
          tests++; fails++;
          $display("FAIL orphan_grant: grant %b with nothing outstanding", grant);
        end else begin
          xact_t e;
          e = (grant == 2'b01) ? qa[0] : qb[0];
          chk("bus_request", 32'(bus.request), 32'd1);
          chk("bus_rw", 32'(bus.rw), 32'(e.rw));
          chk("bus_address", bus.address, e.addr);
          if (e.rw) chk("bus_wdata", bus.wdata, e.wdata);
        end
      end
      if (pa.ready && qa.size() > 0) begin
        chk("pa_rdata", pa.rdata, qa[0].rdata);
        void'(qa.pop_front());
      end
      if (pb.ready && qb.size() > 0) begin
        chk("pb_rdata", pb.rdata, qb[0].rdata);
        void'(qb.pop_front());
      end
      prev_done = bus.ready && grant != 2'b00;
      prev_g    = grant;
      prev_pa   = pa.request;
      prev_pb   = pb.request;
      prev_rst  = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int apos[$];
    pa.request = 1'b0; pa.rw = 1'b0; pa.address = '0; pa.wdata = '0;
    pb.request = 1'b0; pb.rw = 1'b0; pb.address = '0; pb.wdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busreq", 32'(bus.request), 32'd0);
    chk("rst_busrw", 32'(bus.rw), 32'd0);
    chk("rst_busaddr", bus.address, 32'd0);
    chk("rst_buswdata", bus.wdata, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pa_ready", 32'(pa.ready), 32'd0);
    chk("rst_pb_ready", 32'(pb.ready), 32'd0);
    chk("rst_pa_rdata", pa.rdata, 32'd0);
    chk("rst_pb_rdata", pb.rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // 1: lone A write
    fixed_dly = 3; glog.delete();
    a_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    idle(2);
    chk("t1_grants", glog.size(), 1);
    if (glog.size() > 0) chk("t1_owner", 32'(glog[0]), 32'd1);

    // 2: A read with a known VRAM word
    fixed_dly = 1; force_rd = 1'b1; force_val = 32'h1234_5678;
    a_xfer(1'b0, 32'h40, 32'h0, 1'b0);
    force_rd = 1'b0;
    idle(2);

    // 3: simultaneous A and B, count 0 -> B then A
    fixed_dly = -1; glog.delete();
    fork
      a_xfer(1'b0, 32'h300, 32'h0, 1'b0);
      b_xfer(1'b0, 32'h400, 32'h0, 1'b0);
    join
    idle(2);
    chk("t3_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t3_first", 32'(glog[0]), 32'd2);
      chk("t3_second", 32'(glog[1]), 32'd1);
    end

    // 4: B streams 160 reads while A keeps 3 writes pending
    fixed_dly = 0; glog.delete();
    fork
      for (int i = 0; i < 3; i++) a_xfer(1'b1, 32'h1000 + 32'(4 * i), $urandom, i < 2);
      for (int i = 0; i < 160; i++) b_xfer(1'b0, 32'h8000 + 32'(4 * i), 32'h0, i < 159);
    join
    idle(2);
    chk("t4_total", glog.size(), 163);
    foreach (glog[k]) if (glog[k] == 2'b01) apos.push_back(k);
    chk("t4_a_count", apos.size(), 3);
    if (apos.size() == 3) begin
      chk("t4_a0_pos", apos[0], MAXB);
      chk("t4_a1_pos", apos[1], 2 * MAXB + 1);
      chk("t4_a2_pos", apos[2], 3 * MAXB + 2);
    end

    // 5: B back-to-back with request held, address stepping
    fixed_dly = -1; glog.delete(); alog.delete();
    b_xfer(1'b0, 32'h0, 32'h0, 1'b1);
    b_xfer(1'b0, 32'h4, 32'h0, 1'b1);
    b_xfer(1'b0, 32'h8, 32'h0, 1'b0);
    idle(2);
    chk("t5_count", alog.size(), 3);
    if (alog.size() == 3) begin
      chk("t5_addr0", alog[0], 32'h0);
      chk("t5_addr1", alog[1], 32'h4);
      chk("t5_addr2", alog[2], 32'h8);
    end

    // 6: reset during BUSY_A, late bus ready
    rsp_en = 1'b0;
    begin
      xact_t x;
      x.rw = 1'b1; x.addr = 32'h200; x.wdata = 32'hCAFE_F00D; x.rdata = '0;
      qa.push_back(x);
    end
    pa.request = 1'b1; pa.rw = 1'b1; pa.address = 32'h200; pa.wdata = 32'hCAFE_F00D;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (grant == 2'b01) break;
    end
    chk("t6_grantA", 32'(grant), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; pa.request = 1'b0; qa.delete();
    @(posedge clk); #1;
    rst = 1'b0; bus.ready = 1'b1; bus.rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("t6_no_ready", 32'(pa.ready), 32'd0);
    chk("t6_busreq", 32'(bus.request), 32'd0);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_busaddr", bus.address, 32'd0);
    chk("t6_rdata", pa.rdata, 32'd0);
    @(posedge clk); #1;
    bus.ready = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    chk("t6_still_idle", 32'(grant), 32'd0);
    idle(1);

    // random traffic on both ports
    fixed_dly = -1;
    fork
      for (int i = 0; i < 60; i++) begin
        bit h;
        h = (i < 59) && ($urandom_range(0, 1) == 1);
        a_xfer(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, h);
        if (!h) idle($urandom_range(0, 3));
      end
      for (int i = 0; i < 80; i++) begin
        bit h;
        h = (i < 79) && ($urandom_range(0, 3) != 0);
        b_xfer(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, h);
        if (!h) idle($urandom_range(0, 2));
      end
    join
    idle(3);
    chk("rand_qa_drained", qa.size(), 0);
    chk("rand_qb_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
